// File: rtl/ppf_axis_ch_serializer_pkg.sv
// rtl/ppf_axis_ch_serializer_pkg.sv - shared constants and types for the PPF channel serializer
package ppf_pkg;
   localparam int CH_NUM     = 8;
   localparam int CH_IDX_W   = 3;
   localparam int PPF_DATA_W = 64;

   localparam logic [CH_IDX_W-1:0] LAST_IDX = CH_IDX_W'(CH_NUM - 1);

   typedef logic signed [PPF_DATA_W-1:0] ch_data_t;
   typedef ch_data_t frame_t [CH_NUM];

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;
endpackage

// File: rtl/ppf_axis_ch_serializer_if.sv
// rtl/ppf_axis_ch_serializer_if.sv - AXI-Stream master bundle carrying one channel sample per beat
interface ppf_axis_ch_serializer_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0]        M_TDATA;
   logic                         M_TVALID;
   logic                         M_TREADY;
   logic                         M_TLAST;
   logic [ppf_pkg::CH_IDX_W-1:0] M_TUSER;

   modport master (output M_TDATA, output M_TVALID, output M_TLAST, output M_TUSER, input M_TREADY);
   modport slave  (input M_TDATA, input M_TVALID, input M_TLAST, input M_TUSER, output M_TREADY);
endinterface

// File: rtl/ppf_axis_ch_serializer_frame_buf.sv
// rtl/ppf_axis_ch_serializer_frame_buf.sv - two-slot frame store with write/read pointers and fill count
module ppf_frame_buf
   import ppf_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic signed [DATA_WIDTH-1:0] wr_data_i [CH_NUM],
   input  logic                         rd_slot_i,
   input  logic [CH_IDX_W-1:0]          rd_idx_i,
   output logic signed [DATA_WIDTH-1:0] rd_data_o,
   output logic                         rd_ptr_o,
   output logic [1:0]                   fill_o,
   output logic                         full_o,
   output logic                         empty_o
);
   logic signed [DATA_WIDTH-1:0] mem_q [2][CH_NUM];
   logic                         wr_ptr_q, wr_ptr_d;
   logic                         rd_ptr_q, rd_ptr_d;
   logic [1:0]                   fill_q, fill_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      if (push_i && !pop_i)      fill_d = fill_q + 2'd1;
      else if (pop_i && !push_i) fill_d = fill_q - 2'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fill_q   <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Sample storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         for (int c = 0; c < CH_NUM; c++) begin
            mem_q[wr_ptr_q][c] <= wr_data_i[c];
         end
      end
   end

   assign rd_data_o = mem_q[rd_slot_i][rd_idx_i];
   assign rd_ptr_o  = rd_ptr_q;
   assign fill_o    = fill_q;
   assign full_o    = (fill_q == 2'd2);
   assign empty_o   = (fill_q == 2'd0);
endmodule

// File: rtl/ppf_axis_ch_serializer.sv
// rtl/ppf_axis_ch_serializer.sv - serializes 8 PPF channel outputs per frame onto one AXI-Stream master
// Optional dropped-frame counter port ovf_cnt_o enabled by macro PPF_SER_OVF_CNT_EN.
module ppf_axis_ch_serializer
   import ppf_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int OVF_CNT_WIDTH = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic                         frame_valid_i,
   input  logic signed [DATA_WIDTH-1:0] channel0_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel1_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel2_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel3_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel4_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel5_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel6_data_i,
   input  logic signed [DATA_WIDTH-1:0] channel7_data_i,
   ppf_axis_ch_serializer_if.master     m_axis,
   output logic                         overflow_o,
   output logic                         busy_o
`ifdef PPF_SER_OVF_CNT_EN
   ,
   output logic [OVF_CNT_WIDTH-1:0]     ovf_cnt_o
`endif
);
   if (OVF_CNT_WIDTH < 1) begin : g_bad_ovf_w
      $error("OVF_CNT_WIDTH must be at least 1");
   end

   logic signed [DATA_WIDTH-1:0] ch_in [CH_NUM];
   assign ch_in[0] = channel0_data_i;
   assign ch_in[1] = channel1_data_i;
   assign ch_in[2] = channel2_data_i;
   assign ch_in[3] = channel3_data_i;
   assign ch_in[4] = channel4_data_i;
   assign ch_in[5] = channel5_data_i;
   assign ch_in[6] = channel6_data_i;
   assign ch_in[7] = channel7_data_i;

   ser_state_t                   state_q, state_d;
   logic [CH_IDX_W-1:0]          idx_q, idx_d;
   logic                         tvalid_q, tvalid_d;
   logic                         tlast_q, tlast_d;
   logic signed [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                         ovf_q;

   logic                         rd_slot;
   logic [CH_IDX_W-1:0]          rd_idx;
   logic signed [DATA_WIDTH-1:0] rd_data;
   logic                         rd_ptr;
   logic [1:0]                   fill;
   logic                         full, empty;
   logic                         hs, pop, push, drop;

   assign hs   = tvalid_q & m_axis.M_TREADY;
   assign pop  = hs & tlast_q;
   assign push = frame_valid_i & (~full | pop);
   assign drop = frame_valid_i & full & ~pop;

   ppf_frame_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk_i     (ACLK),
      .rst_i     (ARESET),
      .push_i    (push),
      .pop_i     (pop),
      .wr_data_i (ch_in),
      .rd_slot_i (rd_slot),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data),
      .rd_ptr_o  (rd_ptr),
      .fill_o    (fill),
      .full_o    (full),
      .empty_o   (empty)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      rd_slot  = rd_ptr;
      rd_idx   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d  = SEND;
               idx_d    = '0;
               rd_idx   = '0;
               tvalid_d = 1'b1;
               tdata_d  = rd_data;
               tlast_d  = 1'b0;
            end
         end
         SEND: begin
            if (hs) begin
               if (idx_q != LAST_IDX) begin
                  idx_d   = idx_q + CH_IDX_W'(1);
                  rd_idx  = idx_d;
                  tdata_d = rd_data;
                  tlast_d = (idx_d == LAST_IDX);
               end else begin
                  idx_d   = '0;
                  rd_slot = ~rd_ptr;
                  rd_idx  = '0;
                  tlast_d = 1'b0;
                  if (full || push) begin
                     // A frame landing in the idle slot this very cycle is not in storage yet.
                     tdata_d = (push && !full) ? ch_in[0] : rd_data;
                  end else begin
                     state_d  = IDLE;
                     tvalid_d = 1'b0;
                     tdata_d  = '0;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         ovf_q    <= drop;
      end
   end

`ifdef PPF_SER_OVF_CNT_EN
   logic [OVF_CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cnt_q <= '0;
      end else if (drop && (cnt_q != '1)) begin
         cnt_q <= cnt_q + OVF_CNT_WIDTH'(1);
      end
   end

   assign ovf_cnt_o = cnt_q;
`else
`endif

   assign m_axis.M_TDATA  = tdata_q;
   assign m_axis.M_TVALID = tvalid_q;
   assign m_axis.M_TLAST  = tlast_q;
   assign m_axis.M_TUSER  = idx_q;
   assign overflow_o      = ovf_q;
   assign busy_o          = (fill != 2'd0);
endmodule
